// File: rtl/sb_rr_arbiter_if.sv
// Requester-side and downstream-side handshake bundle for sb_rr_arbiter.
// The slave modport is the arbiter's view; master is the view of whoever drives it.
interface sb_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [DATA_WIDTH-1:0]         out_data_o;
    logic [ID_WIDTH-1:0]           out_id_o;
    logic                          out_last_o;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic                          lock_o;

    modport slave (
        input  req_data_i, req_last_i, req_valid_i, out_ready_i,
        output req_ready_o, out_data_o, out_id_o, out_last_o, out_valid_o, lock_o
    );

    modport master (
        output req_data_i, req_last_i, req_valid_i, out_ready_i,
        input  req_ready_o, out_data_o, out_id_o, out_last_o, out_valid_o, lock_o
    );
endinterface

// File: rtl/sb_rr_arbiter.sv
// N-to-1 round-robin arbiter with packet lock and a registered, ID-tagged output stage.
// A packet's grant is held from its first accepted beat until its last beat is accepted.
module sb_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    sb_rr_arbiter_if.slave  arb
);
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [ID_WIDTH-1:0]   r_lock_id, w_lock_id_nxt;
    logic [ID_WIDTH-1:0]   w_grant, w_grant_inc;
    logic                  w_grant_vld, w_grant_last;
    logic                  w_stage_free, w_accept;

    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic                  r_out_last, r_out_valid;

    // Grant selection: locked requester only, otherwise first valid at or after rr_ptr.
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        w_grant     = r_rr_ptr;
        w_grant_vld = 1'b0;
        idx         = 0;
        if (r_state == ST_LOCKED) begin
            w_grant     = r_lock_id;
            w_grant_vld = arb.req_valid_i[r_lock_id];
        end else begin
            // Walk offsets high to low so the smallest offset with a valid request wins.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (arb.req_valid_i[idx]) begin
                    w_grant     = ID_WIDTH'(idx);
                    w_grant_vld = 1'b1;
                end
            end
        end
    end

    assign w_grant_last = arb.req_last_i[w_grant];
    assign w_stage_free = ~r_out_valid | arb.out_ready_i;
    assign w_accept     = rst_n & w_grant_vld & w_stage_free;
    assign w_grant_inc  = (w_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant + ID_WIDTH'(1);

    always_comb begin
        arb.req_ready_o          = '0;
        arb.req_ready_o[w_grant] = w_accept;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_lock_id_nxt = r_lock_id;
        if (w_accept) begin
            if (w_grant_last) begin
                w_state_nxt  = ST_IDLE;
                w_rr_ptr_nxt = w_grant_inc;
            end else begin
                w_state_nxt   = ST_LOCKED;
                w_lock_id_nxt = w_grant;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    // Output stage reloads on accept even when popping in the same cycle, keeping full rate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= arb.req_data_i[w_grant*DATA_WIDTH +: DATA_WIDTH];
            r_out_id    <= w_grant;
            r_out_last  <= w_grant_last;
        end else if (arb.out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign arb.out_valid_o = r_out_valid;
    assign arb.out_data_o  = r_out_data;
    assign arb.out_id_o    = r_out_id;
    assign arb.out_last_o  = r_out_last;
    assign arb.lock_o      = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_sb_rr_arbiter.sv
// Directed bench for sb_rr_arbiter: reset, rotation, packet lock, backpressure,
// lock bubbles with pointer wrap, and reset in the middle of a packet.
module tb_sb_rr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sb_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) u_if ();

    sb_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic v, input logic l, input logic [7:0] d);
        u_if.req_valid_i[i]                       = v;
        u_if.req_last_i[i]                        = l;
        u_if.req_data_i[i*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    task automatic clear_reqs();
        u_if.req_valid_i = '0;
        u_if.req_last_i  = '0;
        u_if.req_data_i  = '0;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        u_if.out_ready_i = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, 1'b1, 8'(i));
        cycle();
        cycle();
        checks++;
        if (u_if.req_ready_o !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b want 0000", u_if.req_ready_o);
        end
        checks++;
        if (u_if.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", u_if.out_valid_o);
        end
        checks++;
        if (u_if.out_id_o !== 2'd0) begin
            errors++; $display("FAIL reset_out_id: got %0d want 0", u_if.out_id_o);
        end
        checks++;
        if (u_if.lock_o !== 1'b0) begin
            errors++; $display("FAIL reset_lock: got %b want 0", u_if.lock_o);
        end
        clear_reqs();
        rst_n = 1'b1;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ready;
        for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, 1'b1, 8'(8'h10 + i));
        for (int c = 0; c < 8; c++) begin
            exp_ready = 4'b0001 << (c % 4);
            #1;
            checks++;
            if (u_if.req_ready_o !== exp_ready) begin
                errors++; $display("FAIL fair_ready[%0d]: got %b want %b", c, u_if.req_ready_o, exp_ready);
            end
            cycle();
            checks++;
            if (u_if.out_valid_o !== 1'b1 || u_if.out_id_o !== 2'(c % 4) ||
                u_if.out_data_o !== 8'(8'h10 + c % 4)) begin
                errors++;
                $display("FAIL fair_out[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         c, u_if.out_valid_o, u_if.out_id_o, u_if.out_data_o, c % 4, 8'(8'h10 + c % 4));
            end
        end
        clear_reqs();
        cycle();
        checks++;
        if (u_if.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL fair_drain: got out_valid=%b want 0", u_if.out_valid_o);
        end
    endtask

    task automatic test_lock();
        logic [7:0] beat_data [3];
        beat_data[0] = 8'hB1; beat_data[1] = 8'hB2; beat_data[2] = 8'hB3;
        drive(2, 1'b1, 1'b1, 8'h2C);
        for (int b = 0; b < 3; b++) begin
            drive(1, 1'b1, (b == 2), beat_data[b]);
            #1;
            checks++;
            if (u_if.req_ready_o !== 4'b0010) begin
                errors++; $display("FAIL lock_ready[%0d]: got %b want 0010", b, u_if.req_ready_o);
            end
            cycle();
            checks++;
            if (u_if.out_id_o !== 2'd1 || u_if.out_data_o !== beat_data[b] ||
                u_if.out_last_o !== (b == 2) || u_if.lock_o !== (b != 2)) begin
                errors++;
                $display("FAIL lock_beat[%0d]: got id=%0d d=%h last=%b lock=%b want id=1 d=%h last=%b lock=%b",
                         b, u_if.out_id_o, u_if.out_data_o, u_if.out_last_o, u_if.lock_o,
                         beat_data[b], (b == 2), (b != 2));
            end
        end
        drive(1, 1'b0, 1'b0, 8'h00);
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b0100) begin
            errors++; $display("FAIL lock_next_ready: got %b want 0100", u_if.req_ready_o);
        end
        cycle();
        checks++;
        if (u_if.out_id_o !== 2'd2 || u_if.out_data_o !== 8'h2C || u_if.lock_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_next_out: got id=%0d d=%h lock=%b want id=2 d=2c lock=0",
                     u_if.out_id_o, u_if.out_data_o, u_if.lock_o);
        end
        clear_reqs();
        cycle();
    endtask

    task automatic test_backpressure();
        drive(0, 1'b1, 1'b1, 8'hA5);
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL bp_first_ready: got %b want 0001", u_if.req_ready_o);
        end
        cycle();
        u_if.out_ready_i = 1'b0;
        drive(0, 1'b1, 1'b1, 8'h5A);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (u_if.req_ready_o !== 4'b0000 || u_if.out_valid_o !== 1'b1 || u_if.out_data_o !== 8'hA5) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ready=%b v=%b d=%h want ready=0000 v=1 d=a5",
                         c, u_if.req_ready_o, u_if.out_valid_o, u_if.out_data_o);
            end
            cycle();
        end
        u_if.out_ready_i = 1'b1;
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL bp_release_ready: got %b want 0001", u_if.req_ready_o);
        end
        cycle();
        checks++;
        if (u_if.out_valid_o !== 1'b1 || u_if.out_data_o !== 8'h5A || u_if.out_id_o !== 2'd0) begin
            errors++;
            $display("FAIL bp_next_beat: got v=%b d=%h id=%0d want v=1 d=5a id=0",
                     u_if.out_valid_o, u_if.out_data_o, u_if.out_id_o);
        end
        clear_reqs();
        cycle();
        checks++;
        if (u_if.out_valid_o !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup: got out_valid=%b want 0", u_if.out_valid_o);
        end
    endtask

    task automatic test_bubble_wrap();
        drive(3, 1'b1, 1'b0, 8'hC1);
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b1000) begin
            errors++; $display("FAIL bub_first_ready: got %b want 1000", u_if.req_ready_o);
        end
        cycle();
        drive(3, 1'b0, 1'b0, 8'hC1);
        drive(0, 1'b1, 1'b1, 8'h0D);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (u_if.req_ready_o !== 4'b0000 || u_if.lock_o !== 1'b1) begin
                errors++;
                $display("FAIL bub_hold[%0d]: got ready=%b lock=%b want ready=0000 lock=1",
                         c, u_if.req_ready_o, u_if.lock_o);
            end
            cycle();
        end
        drive(3, 1'b1, 1'b1, 8'hC2);
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b1000) begin
            errors++; $display("FAIL bub_last_ready: got %b want 1000", u_if.req_ready_o);
        end
        cycle();
        checks++;
        if (u_if.out_id_o !== 2'd3 || u_if.out_data_o !== 8'hC2 || u_if.lock_o !== 1'b0) begin
            errors++;
            $display("FAIL bub_last_out: got id=%0d d=%h lock=%b want id=3 d=c2 lock=0",
                     u_if.out_id_o, u_if.out_data_o, u_if.lock_o);
        end
        drive(3, 1'b0, 1'b0, 8'h00);
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL bub_wrap_ready: got %b want 0001", u_if.req_ready_o);
        end
        cycle();
        checks++;
        if (u_if.out_id_o !== 2'd0 || u_if.out_data_o !== 8'h0D) begin
            errors++;
            $display("FAIL bub_wrap_out: got id=%0d d=%h want id=0 d=0d", u_if.out_id_o, u_if.out_data_o);
        end
        clear_reqs();
        cycle();
    endtask

    task automatic test_reset_mid_packet();
        // A single beat from req1 first moves the pointer to 2, so a stale pointer would favour req2.
        drive(1, 1'b1, 1'b1, 8'h70);
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b0010) begin
            errors++; $display("FAIL rmid_pre_ready: got %b want 0010", u_if.req_ready_o);
        end
        cycle();
        drive(1, 1'b0, 1'b0, 8'h00);
        drive(2, 1'b1, 1'b0, 8'hE1);
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b0100) begin
            errors++; $display("FAIL rmid_pkt_ready: got %b want 0100", u_if.req_ready_o);
        end
        cycle();
        drive(2, 1'b1, 1'b0, 8'hE2);
        cycle();
        checks++;
        if (u_if.lock_o !== 1'b1 || u_if.out_data_o !== 8'hE2) begin
            errors++;
            $display("FAIL rmid_locked: got lock=%b d=%h want lock=1 d=e2", u_if.lock_o, u_if.out_data_o);
        end
        rst_n = 1'b0;
        drive(1, 1'b1, 1'b1, 8'h71);
        drive(2, 1'b1, 1'b0, 8'hE3);
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b0000) begin
            errors++; $display("FAIL rmid_rst_ready: got %b want 0000", u_if.req_ready_o);
        end
        cycle();
        checks++;
        if (u_if.lock_o !== 1'b0 || u_if.out_valid_o !== 1'b0 || u_if.out_id_o !== 2'd0) begin
            errors++;
            $display("FAIL rmid_rst_state: got lock=%b v=%b id=%0d want lock=0 v=0 id=0",
                     u_if.lock_o, u_if.out_valid_o, u_if.out_id_o);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (u_if.req_ready_o !== 4'b0010) begin
            errors++; $display("FAIL rmid_after_ready: got %b want 0010", u_if.req_ready_o);
        end
        cycle();
        checks++;
        if (u_if.out_valid_o !== 1'b1 || u_if.out_id_o !== 2'd1 || u_if.out_data_o !== 8'h71) begin
            errors++;
            $display("FAIL rmid_after_out: got v=%b id=%0d d=%h want v=1 id=1 d=71",
                     u_if.out_valid_o, u_if.out_id_o, u_if.out_data_o);
        end
        clear_reqs();
        cycle();
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        rst_n            = 1'b0;
        u_if.out_ready_i = 1'b1;
        u_if.req_valid_i = '0;
        u_if.req_last_i  = '0;
        u_if.req_data_i  = '0;

        test_reset();
        test_fairness();
        test_lock();
        test_backpressure();
        test_bubble_wrap();
        test_reset_mid_packet();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
